// File: rtl/mm2s_pkg.sv
// mm2s_pkg: bank/read-FSM state types and 32-bit saturation for the mm2s_pp result drain
package mm2s_pkg;
  typedef enum logic [1:0] {FREE, FILLING, FULL, DRAINING} bank_state_t;
  typedef enum logic [1:0] {IDLE, FETCH, STREAM} rd_state_t;
  localparam logic signed [63:0] S32_MAX = 64'sd2147483647;
  localparam logic signed [63:0] S32_MIN = -64'sd2147483648;
  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    return (v > S32_MAX) ? 32'h7FFF_FFFF : (v < S32_MIN) ? 32'h8000_0000 : v[31:0];
  endfunction
endpackage

// File: rtl/mm2s_bank_ram.sv
// mm2s_bank_ram: simple dual-port row RAM with a registered read port
module mm2s_bank_ram
  import mm2s_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  // write port and one-cycle registered read port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/mm2s_pp.sv
// mm2s_pp: ping-pong row buffer draining N2-wide result rows as 32-bit AXI-Stream beats (optional clamp: MM2S_SATURATE_EN)
module mm2s_pp
  import mm2s_pkg::*;
#(
  parameter int D_W          = 32,
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ROWS_MAX     = 4096,
  parameter int ADDR_W       = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    row_valid,
  input  logic [N2*D_W-1:0]       row_data,
  input  logic                    row_last,
  output logic                    row_ready,
  input  logic [MATRIXSIZE_W-1:0] BLOCKS,
  output logic [31:0]             m_axis_mm2s_tdata,
  output logic                    m_axis_mm2s_tvalid,
  input  logic                    m_axis_mm2s_tready,
  output logic                    m_axis_mm2s_tlast,
  output logic                    done_drain,
  output logic                    err_overflow
);
  localparam int LW = $clog2(N2);
  localparam int CW = ADDR_W + 1;
  bank_state_t r_bst [2];
  logic [CW-1:0] r_cnt [2];
  rd_state_t r_st;
  logic r_run, r_wr_bank, r_rd_bank, r_err, r_done, r_tvalid, r_buf_v, r_buf_last, r_last_row;
  logic [ADDR_W-1:0] r_wr_row;
  logic [CW-1:0] r_rd_row;
  logic [LW-1:0] r_lane;
  logic [MATRIXSIZE_W-1:0] r_blk;
  logic [N2*D_W-1:0] r_sh;
  logic [N2*D_W-1:0] w_rdata [2];
  logic w_wr, w_close, w_acc, w_lane_end, w_row_done, w_load, w_bank_end, w_start, w_more, w_re;
  logic [CW-1:0] w_fetch_row;
  logic [MATRIXSIZE_W-1:0] w_blk_m1;

  assign row_ready   = r_run & (r_bst[r_wr_bank] == FREE || r_bst[r_wr_bank] == FILLING);
  assign w_wr        = row_valid & row_ready;
  assign w_close     = w_wr & (row_last | (r_wr_row == ADDR_W'(ROWS_MAX - 1)));
  assign w_acc       = r_tvalid & m_axis_mm2s_tready;
  assign w_lane_end  = r_lane == LW'(N2 - 1);
  assign w_row_done  = w_acc & w_lane_end;
  // rowbuf (the RAM output register) moves into the shifter whenever the shifter is empty or finishing
  assign w_load      = r_buf_v & (!r_tvalid | w_row_done);
  assign w_bank_end  = w_row_done & r_last_row;
  assign w_start     = (r_st == IDLE) & (r_bst[r_rd_bank] == FULL);
  assign w_more      = (r_st != IDLE) & (r_rd_row < r_cnt[r_rd_bank]) & (!r_buf_v | w_load);
  assign w_re        = w_start | w_more;
  assign w_fetch_row = w_start ? '0 : r_rd_row;
  assign w_blk_m1    = (BLOCKS == '0) ? '0 : BLOCKS - 1'b1;

  assign m_axis_mm2s_tvalid = r_tvalid;
  assign m_axis_mm2s_tlast  = r_tvalid & w_lane_end & r_last_row & (r_blk == w_blk_m1);
  assign done_drain         = r_done;
  assign err_overflow       = r_err;
`ifdef MM2S_SATURATE_EN
  assign m_axis_mm2s_tdata = sat32({{(64-D_W){r_sh[D_W-1]}}, r_sh[D_W-1:0]});
`else
  assign m_axis_mm2s_tdata = 32'({{(64-D_W){r_sh[D_W-1]}}, r_sh[D_W-1:0]});
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mm2s_bank_ram #(.W(N2*D_W), .DEPTH(ROWS_MAX), .AW(ADDR_W)) u_ram (
      .clk    (clk),
      .i_we   (w_wr & (r_wr_bank == 1'(b))),
      .i_waddr(r_wr_row),
      .i_wdata(row_data),
      .i_re   (w_re & (r_rd_bank == 1'(b))),
      .i_raddr(w_fetch_row[ADDR_W-1:0]),
      .o_rdata(w_rdata[b])
    );
  end

  // bank ownership: read side claims/frees first so a same-cycle write to that bank wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_wr_bank <= 1'b0;
      r_wr_row  <= '0;
      r_err     <= 1'b0;
      r_bst[0]  <= FREE;
      r_bst[1]  <= FREE;
      r_cnt[0]  <= '0;
      r_cnt[1]  <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_start) r_bst[r_rd_bank] <= DRAINING;
      if (w_bank_end) r_bst[r_rd_bank] <= FREE;
      if (w_wr) begin
        r_bst[r_wr_bank] <= w_close ? FULL : FILLING;
        r_wr_row <= w_close ? '0 : r_wr_row + 1'b1;
        if (w_close) r_cnt[r_wr_bank] <= {1'b0, r_wr_row} + 1'b1;
        if (w_close) r_wr_bank <= !r_wr_bank;
        if (w_close & !row_last) r_err <= 1'b1;
      end
    end

  // read FSM: fetch row 0, then keep one row prefetched ahead of the shifter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_st       <= IDLE;
      r_rd_bank  <= 1'b0;
      r_rd_row   <= '0;
      r_buf_v    <= 1'b0;
      r_buf_last <= 1'b0;
      r_blk      <= '0;
    end else begin
      r_st    <= w_start ? FETCH : (r_st == FETCH && w_load) ? STREAM : w_bank_end ? IDLE : r_st;
      r_buf_v <= w_re | (r_buf_v & !w_load);
      if (w_re) r_rd_row <= w_fetch_row + 1'b1;
      if (w_re) r_buf_last <= (w_fetch_row + 1'b1) == r_cnt[r_rd_bank];
      if (w_bank_end) r_rd_bank <= !r_rd_bank;
      if (w_bank_end) r_blk <= (r_blk == w_blk_m1) ? '0 : r_blk + 1'b1;
    end

  // output shifter: lane 0 drives tdata, shift on each accepted beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tvalid   <= 1'b0;
      r_sh       <= '0;
      r_lane     <= '0;
      r_last_row <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done   <= w_acc & m_axis_mm2s_tlast;
      r_tvalid <= w_load | (r_tvalid & !w_row_done);
      if (w_load) begin
        r_sh       <= w_rdata[r_rd_bank];
        r_lane     <= '0;
        r_last_row <= r_buf_last;
      end else if (w_acc) begin
        r_sh   <= r_sh >> D_W;
        r_lane <= r_lane + 1'b1;
      end
    end
endmodule

// File: tb/tb_mm2s_pp.sv
// tb_mm2s_pp: directed self-checking bench for mm2s_pp (default and D_W=40/ROWS_MAX=4 instances)
module tb_mm2s_pp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;

  logic         m_valid = 1'b0;
  logic         m_last = 1'b0;
  logic [127:0] m_data = '0;
  logic [15:0]  m_blocks = 16'd1;
  logic         m_tready = 1'b1;
  logic         m_ready, m_tvalid, m_tlast, m_done, m_err;
  logic [31:0]  m_tdata;

  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic [79:0]  s_data = '0;
  logic [15:0]  s_blocks = 16'd0;
  logic         s_tready = 1'b1;
  logic         s_ready, s_tvalid, s_tlast, s_done, s_err;
  logic [31:0]  s_tdata;

  mm2s_pp u_main (
    .clk(clk), .rst_n(rst_n), .row_valid(m_valid), .row_data(m_data), .row_last(m_last),
    .row_ready(m_ready), .BLOCKS(m_blocks), .m_axis_mm2s_tdata(m_tdata),
    .m_axis_mm2s_tvalid(m_tvalid), .m_axis_mm2s_tready(m_tready), .m_axis_mm2s_tlast(m_tlast),
    .done_drain(m_done), .err_overflow(m_err)
  );

  mm2s_pp #(.D_W(40), .N2(2), .ROWS_MAX(4), .ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .row_valid(s_valid), .row_data(s_data), .row_last(s_last),
    .row_ready(s_ready), .BLOCKS(s_blocks), .m_axis_mm2s_tdata(s_tdata),
    .m_axis_mm2s_tvalid(s_tvalid), .m_axis_mm2s_tready(s_tready), .m_axis_mm2s_tlast(s_tlast),
    .done_drain(s_done), .err_overflow(s_err)
  );

  logic [32:0] mq[$];
  logic [32:0] sq[$];
  logic        m_stall = 1'b0;
  logic [32:0] m_prev = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // accepted-beat capture and hold-while-stalled check for the main instance
  always @(negedge clk) begin
    if (!rst_n) m_stall <= 1'b0;
    else begin
      if (m_stall) begin
        chk("hold_tvalid", 32'(m_tvalid), 32'd1);
        chk("hold_tdata", m_tdata, m_prev[31:0]);
        chk("hold_tlast", 32'(m_tlast), 32'(m_prev[32]));
      end
      if (m_tvalid && m_tready) mq.push_back({m_tlast, m_tdata});
      m_stall <= m_tvalid & !m_tready;
      m_prev  <= {m_tlast, m_tdata};
    end
  end

  // accepted-beat capture for the small instance
  always @(negedge clk)
    if (rst_n && s_tvalid && s_tready) sq.push_back({s_tlast, s_tdata});

  function automatic logic [127:0] row4(input int a);
    return {32'(a + 3), 32'(a + 2), 32'(a + 1), 32'(a)};
  endfunction

  function automatic logic [79:0] row2(input int a);
    return {40'(a + 1), 40'(a)};
  endfunction

  task automatic put_m(input logic [127:0] d, input logic last);
    int n = 0;
    m_valid = 1'b1;
    m_data  = d;
    m_last  = last;
    while (!m_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("m_row_accept", 32'(m_ready), 32'd1);
    @(posedge clk); #1;
    m_valid = 1'b0;
    m_last  = 1'b0;
  endtask

  task automatic put_s(input logic [79:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s_row_accept", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_m(input int n);
    int k = 0;
    while (mq.size() < n && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("m_beat_count", 32'(mq.size()), 32'(n));
  endtask

  task automatic wait_s(input int n);
    int k = 0;
    while (sq.size() < n && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("s_beat_count", 32'(sq.size()), 32'(n));
  endtask

  logic [31:0] sat_exp;

  initial begin
`ifdef MM2S_SATURATE_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h0000_0000;
`endif
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_row_ready", 32'(m_ready), 32'd0);
    chk("rst_s_err", 32'(s_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(m_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(m_ready), 32'd1);

    // single block, tready high: first beat three cycles after row_last
    put_m(row4(1), 1'b0);
    put_m(row4(5), 1'b1);
    @(negedge clk);
    chk("t1_c1_tvalid", 32'(m_tvalid), 32'd0);
    @(negedge clk);
    chk("t1_c2_tvalid", 32'(m_tvalid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_tvalid", 32'(m_tvalid), 32'd1);
      chk("t1_tdata", m_tdata, 32'(i + 1));
      chk("t1_tlast", 32'(m_tlast), 32'(i == 7));
      chk("t1_done_low", 32'(m_done), 32'd0);
    end
    @(negedge clk);
    chk("t1_done_pulse", 32'(m_done), 32'd1);
    chk("t1_tvalid_end", 32'(m_tvalid), 32'd0);
    @(negedge clk);
    chk("t1_done_clear", 32'(m_done), 32'd0);
    chk("t1_ready", 32'(m_ready), 32'd1);
    mq.delete();

    // backpressure with tready pattern 1,0,0,1
    put_m(row4(1), 1'b0);
    put_m(row4(5), 1'b1);
    for (int k = 0; k < 80 && mq.size() < 8; k++) begin
      m_tready = (k % 4 == 0) || (k % 4 == 3);
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    chk("t2_count", 32'(mq.size()), 32'd8);
    for (int i = 0; i < 8 && i < mq.size(); i++) begin
      chk("t2_tdata", mq[i][31:0], 32'(i + 1));
      chk("t2_tlast", 32'(mq[i][32]), 32'(i == 7));
    end
    repeat (4) @(posedge clk); #1;
    mq.delete();

    // ping-pong: three 4-row blocks, tready held low while both banks fill
    m_blocks = 16'd3;
    m_tready = 1'b0;
    for (int r = 0; r < 8; r++) put_m(row4(4 * r + 1), r % 4 == 3);
    chk("t3_ready_low", 32'(m_ready), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("t3_ready_still_low", 32'(m_ready), 32'd0);
    chk("t3_first_valid", 32'(m_tvalid), 32'd1);
    chk("t3_first_data", m_tdata, 32'd1);
    m_tready = 1'b1;
    for (int r = 8; r < 12; r++) put_m(row4(4 * r + 1), r % 4 == 3);
    wait_m(48);
    for (int i = 0; i < 48 && i < mq.size(); i++) begin
      chk("t3_tdata", mq[i][31:0], 32'(i + 1));
      chk("t3_tlast", 32'(mq[i][32]), 32'(i == 47));
    end
    mq.delete();
    m_blocks = 16'd1;

    // D_W=40: clamp/truncate, sign extension, overflow close, BLOCKS=0 as 1
    put_s({40'hFF_FFFF_FFFB, 40'h08_0000_0000}, 1'b1);
    put_s(row2(1), 1'b0);
    put_s(row2(3), 1'b0);
    put_s(row2(5), 1'b0);
    chk("s_err_before", 32'(s_err), 32'd0);
    put_s(row2(7), 1'b0);
    chk("s_err_after", 32'(s_err), 32'd1);
    put_s(row2(9), 1'b0);
    put_s(row2(11), 1'b1);
    wait_s(14);
    if (sq.size() >= 14) begin
      chk("s_sat_big", sq[0][31:0], sat_exp);
      chk("s_sat_big_last", 32'(sq[0][32]), 32'd0);
      chk("s_neg5", sq[1][31:0], 32'hFFFF_FFFB);
      chk("s_neg5_last", 32'(sq[1][32]), 32'd1);
      for (int i = 2; i < 14; i++) begin
        chk("s_ovf_tdata", sq[i][31:0], 32'(i - 1));
        chk("s_ovf_tlast", 32'(sq[i][32]), 32'(i == 9 || i == 13));
      end
    end
    chk("s_err_sticky", 32'(s_err), 32'd1);

    // reset during the third beat, then a fresh block
    put_m(row4(101), 1'b0);
    put_m(row4(105), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) chk("t5_pre_tdata", m_tdata, 32'(99 + i));
    end
    rst_n = 1'b0;
    #1;
    chk("t5_tvalid", 32'(m_tvalid), 32'd0);
    chk("t5_tlast", 32'(m_tlast), 32'd0);
    chk("t5_tdata", m_tdata, 32'd0);
    chk("t5_ready", 32'(m_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    @(posedge clk); #1;
    chk("t5_ready_back", 32'(m_ready), 32'd1);
    put_m(row4(201), 1'b0);
    put_m(row4(205), 1'b1);
    wait_m(8);
    for (int i = 0; i < 8 && i < mq.size(); i++) begin
      chk("t5_tdata", mq[i][31:0], 32'(201 + i));
      chk("t5_tlast", 32'(mq[i][32]), 32'(i == 7));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mm2s_pp.md
# mm2s_pp

Result drain for the matrix-multiply datapath: accepts completed N2-wide result rows from the multiply engine, buffers them in two ping-pong banks, and serializes them as 32-bit elements onto an AXI-Stream master toward the MM2S DMA. It is the output-side counterpart of the s2mm loaders. One bank fills while the other drains, so the engine stalls only when both banks are occupied.

## Interface
- D_W, 32, accumulator element width (16..48)
- N2, 4, elements per row (>=2)
- MATRIXSIZE_W, 16, width of size/count inputs
- ROWS_MAX, 4096, row capacity per bank
- ADDR_W, 12, bank row-address width, equal to clog2(ROWS_MAX)
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- row_valid  in  1  result row present
- row_data  in  N2*D_W  packed row; lane i is bits [i*D_W +: D_W]; lane 0 is streamed first
- row_last  in  1  final row of the current block
- row_ready  out  1  write bank can accept a row
- BLOCKS  in  MATRIXSIZE_W  blocks per matrix; 0 is treated as 1
- m_axis_mm2s_tdata  out  32  element
- m_axis_mm2s_tvalid  out  1
- m_axis_mm2s_tready  in  1
- m_axis_mm2s_tlast  out  1  final element of the matrix
- done_drain  out  1  one-cycle pulse after the matrix's final beat is accepted
- err_overflow  out  1  sticky; a bank overran ROWS_MAX

## Operation
- Each bank carries a state: FREE, FILLING, FULL or DRAINING. The bank also stores its row count.
- Write side:
  - wr_bank starts at 0.
  - row_ready = 1 when wr_bank is FREE or FILLING.
  - On row_valid & row_ready, the row is written at wr_row, wr_row increments, and the bank becomes FILLING.
  - The bank becomes FULL on row_last, or when the written row sits at ROWS_MAX-1. In the ROWS_MAX-1 case without row_last, err_overflow is set.
  - When a bank becomes FULL: its row count is latched, wr_row returns to 0, and wr_bank toggles.
- Read FSM states and transitions:
  - IDLE -> FETCH when rd_bank is FULL. The bank becomes DRAINING and row 0 is read.
  - FETCH -> STREAM once rowbuf holds data.
  - STREAM emits lanes 0..N2-1, one per accepted beat.
  - Row r+1 is prefetched into rowbuf while row r serializes from the shift register. With tready held high there are no bubbles.
  - After the last lane of the bank's last row is accepted: the bank becomes FREE, rd_bank toggles, blk_cnt increments, and the FSM returns to IDLE.
- tlast is high on the final lane of the final row when blk_cnt == BLOCKS-1. Acceptance of that beat resets blk_cnt to 0 and pulses done_drain on the next cycle.
- Width rule: if D_W < 32, elements are sign-extended. If D_W > 32, see Configuration.
- AXI rules:
  - tdata and tlast are held stable while tvalid & !tready.
  - tvalid never drops without a handshake.
- Simultaneous events:
  - A bank closing on the write side and the other bank freeing on the read side in the same cycle are both honoured.
  - A FREE transition and a new row write to the same bank in the same cycle: the write wins, and the bank becomes FILLING.
- Reset mid-operation: all banks go FREE, all counters and pointers go to 0, and buffered data is discarded.

## Timing
- Reset values: tvalid 0, tlast 0, tdata 0, done_drain 0, err_overflow 0, row_ready 0. row_ready rises on the first clk edge after rst_n deasserts.
- Latency: row_last accepted in cycle 0, bank FULL in cycle 1, RAM read in cycle 1, rowbuf loaded in cycle 2, first tvalid visible in cycle 3.
- Throughput: 1 element per cycle sustained across rows and across back-to-back FULL banks. Between banks, at most a 2-cycle gap.
- row_ready falls in the cycle after the write that closes a bank, if the other bank is not FREE.

## Configuration
- MM2S_SATURATE_EN applies only when D_W > 32.
- Defined: each element is clamped to [-2^31, 2^31-1].
- Undefined: the low 32 bits are passed through, i.e. truncated.

## Structure
- Package mm2s_pkg holds:
  - bank_state_t (FREE, FILLING, FULL, DRAINING)
  - rd_state_t (IDLE, FETCH, STREAM)
  - the saturation function
- Sub-module mm2s_bank_ram: simple dual-port RAM, N2*D_W wide, ROWS_MAX deep, 1-cycle registered read, instantiated twice.

## Test plan
- Single block: N2=4, BLOCKS=1, 2 rows [1,2,3,4],[5,6,7,8], tready=1. Expect tdata 1..8 in consecutive cycles, first beat in cycle 3, tlast on 8, done_drain one cycle after.
- Backpressure: same data, tready toggling 1,0,0,1,... Expect tdata/tlast held while stalled, sequence unchanged, no dropped or duplicated beats.
- Ping-pong: BLOCKS=3, 4 rows per block, tready=0 throughout. Expect row_ready low after the 8th row. Release tready: all 48 elements in order, tlast only on the 48th.
- Saturation (D_W=40): element 2^35 gives 0x7FFFFFFF with the macro and 0x00000000 without. Element -5 gives 0xFFFFFFFB in both cases.
- Overflow: ROWS_MAX=4, 5 rows without row_last. Expect err_overflow set after row 4, bank closed, row 5 in the other bank.
- Reset mid-stream: rst_n low during the 3rd beat. Expect tvalid 0 immediately and row_ready 0. After release, a fresh block streams from its first element.
